// File: rtl/spi_control.sv
// Bus-facing SPI controller: CTRL/STATUS registers, 4-deep TX and RX FIFOs, and the
// sequencer that feeds words to the shift engine and drives an active-low chip select.
module spi_control #(
  parameter int unsigned DEPTH = 4
) (
  input  logic        raw_clk,
  input  logic        reset,
  input  logic [1:0]  address,
  input  logic [15:0] data_in,
  input  logic        write_enable,
  input  logic        read_enable,
  output logic [15:0] data_out,
  output logic        cs_n,
  output logic        spi_start,
  output logic [3:0]  spi_divisor,
  output logic        spi_width_16,
  output logic [15:0] spi_data_tx,
  input  logic [15:0] spi_data_rx,
  input  logic        spi_busy
);
  localparam int unsigned PtrW = $clog2(DEPTH);
  localparam int unsigned CntW = PtrW + 1;

  typedef enum logic [2:0] {
    StIdle, StCsSetup, StStart, StWaitBusy, StWaitDone, StCapture
  } state_e;

  state_e          r_state;
  logic [6:0]      r_ctrl;
  logic            r_rx_ovf;
  logic            r_tx_ovf;
  logic            r_auto_hold;
  logic            r_spi_start;
  logic [3:0]      r_divisor;
  logic            r_width;
  logic [15:0]     r_data_tx;
  logic [15:0]     r_data_out;
  logic [15:0]     r_tx_mem [DEPTH];
  logic [15:0]     r_rx_mem [DEPTH];
  logic [PtrW-1:0] r_tx_rd;
  logic [PtrW-1:0] r_tx_wr;
  logic [PtrW-1:0] r_rx_rd;
  logic [PtrW-1:0] r_rx_wr;
  logic [CntW-1:0] r_tx_cnt;
  logic [CntW-1:0] r_rx_cnt;

  logic        w_wr_ctrl, w_wr_status, w_wr_tx, w_rd_rx;
  logic        w_tx_empty, w_tx_full, w_rx_empty, w_rx_full;
  logic        w_tx_push, w_tx_pop, w_rx_push, w_rx_pop;
  logic        w_capture, w_active, w_cs_n, w_enter_start;
  logic [15:0] w_tx_head, w_rx_word;

  assign w_wr_ctrl   = write_enable && (address == 2'd0);
  assign w_wr_status = write_enable && (address == 2'd1);
  assign w_wr_tx     = write_enable && (address == 2'd2);
  assign w_rd_rx     = read_enable  && (address == 2'd3);

  assign w_tx_empty = (r_tx_cnt == '0);
  assign w_tx_full  = (r_tx_cnt == CntW'(DEPTH));
  assign w_rx_empty = (r_rx_cnt == '0);
  assign w_rx_full  = (r_rx_cnt == CntW'(DEPTH));

  assign w_cs_n   = ~(r_ctrl[5] | (r_ctrl[6] & r_auto_hold));
  assign w_active = (r_state != StIdle) || !w_tx_empty;

  // Every path into START pops the TX head; IDLE detours through CS_SETUP for auto CS.
  assign w_enter_start = ((r_state == StIdle) && !w_tx_empty && !spi_busy &&
                          !(r_ctrl[6] && w_cs_n)) ||
                         (r_state == StCsSetup) ||
                         ((r_state == StCapture) && !w_tx_empty);

  assign w_capture = (r_state == StCapture);
  assign w_tx_head = r_tx_mem[r_tx_rd];
  assign w_tx_push = w_wr_tx && !w_tx_full;
  assign w_tx_pop  = w_enter_start;
  assign w_rx_pop  = w_rd_rx && !w_rx_empty;
  // A same-cycle pop frees the slot, so a capture into a full FIFO is still accepted.
  assign w_rx_push = w_capture && (!w_rx_full || w_rx_pop);
  assign w_rx_word = r_width ? spi_data_rx : {8'h00, spi_data_rx[7:0]};

  assign data_out     = r_data_out;
  assign cs_n         = w_cs_n;
  assign spi_start    = r_spi_start;
  assign spi_divisor  = r_divisor;
  assign spi_width_16 = r_width;
  assign spi_data_tx  = r_data_tx;

  always_ff @(posedge raw_clk) begin
    if (reset) begin
      r_state     <= StIdle;
      r_spi_start <= 1'b0;
      r_auto_hold <= 1'b0;
      r_divisor   <= 4'd0;
      r_width     <= 1'b0;
      r_data_tx   <= 16'd0;
    end else begin
      r_spi_start <= 1'b0;
      if (w_enter_start) begin
        r_spi_start <= 1'b1;
        r_divisor   <= r_ctrl[3:0];
        r_width     <= r_ctrl[4];
        r_data_tx   <= r_ctrl[4] ? w_tx_head : {8'h00, w_tx_head[7:0]};
      end
      unique case (r_state)
        StIdle: begin
          if (w_enter_start) begin
            r_state <= StStart;
          end else if (!w_tx_empty && !spi_busy) begin
            r_state     <= StCsSetup;
            r_auto_hold <= 1'b1;
          end
        end
        StCsSetup:  r_state <= StStart;
        StStart:    r_state <= StWaitBusy;
        StWaitBusy: if (spi_busy) r_state <= StWaitDone;
        StWaitDone: if (!spi_busy) r_state <= StCapture;
        StCapture: begin
          if (w_enter_start) begin
            r_state <= StStart;
          end else begin
            r_state     <= StIdle;
            r_auto_hold <= 1'b0;
          end
        end
        default: r_state <= StIdle;
      endcase
    end
  end

  always_ff @(posedge raw_clk) begin
    if (reset) begin
      r_ctrl   <= 7'd0;
      r_tx_ovf <= 1'b0;
      r_rx_ovf <= 1'b0;
      r_tx_rd  <= '0;
      r_tx_wr  <= '0;
      r_tx_cnt <= '0;
      r_rx_rd  <= '0;
      r_rx_wr  <= '0;
      r_rx_cnt <= '0;
    end else begin
      if (w_wr_ctrl) r_ctrl <= data_in[6:0];
      r_tx_ovf <= (w_wr_tx && w_tx_full) || (r_tx_ovf && !(w_wr_status && data_in[4]));
      r_rx_ovf <= (w_capture && w_rx_full && !w_rx_pop) ||
                  (r_rx_ovf && !(w_wr_status && data_in[3]));
      if (w_tx_push) r_tx_wr <= r_tx_wr + PtrW'(1);
      if (w_tx_pop)  r_tx_rd <= r_tx_rd + PtrW'(1);
      r_tx_cnt <= r_tx_cnt + CntW'(w_tx_push) - CntW'(w_tx_pop);
      if (w_rx_push) r_rx_wr <= r_rx_wr + PtrW'(1);
      if (w_rx_pop)  r_rx_rd <= r_rx_rd + PtrW'(1);
      r_rx_cnt <= r_rx_cnt + CntW'(w_rx_push) - CntW'(w_rx_pop);
    end
  end

  always_ff @(posedge raw_clk) begin
    if (w_tx_push) r_tx_mem[r_tx_wr] <= data_in;
    if (w_rx_push) r_rx_mem[r_rx_wr] <= w_rx_word;
  end

  always_ff @(posedge raw_clk) begin
    if (reset) begin
      r_data_out <= 16'd0;
    end else if (read_enable) begin
      unique case (address)
        2'd0: r_data_out <= {9'd0, r_ctrl};
        2'd1: r_data_out <= {11'd0, r_tx_ovf, r_rx_ovf, w_rx_empty, w_tx_full, w_active};
        2'd2: r_data_out <= 16'd0;
        2'd3: r_data_out <= w_rx_empty ? 16'd0 : r_rx_mem[r_rx_rd];
        default: r_data_out <= 16'd0;
      endcase
    end
  end

endmodule

// File: tb/tb_spi_control.sv
// Directed bench for spi_control: a loopback engine model, a queue-based transaction model
// checked every cycle, and literal expectations on the register reads.
module tb_spi_control;
  logic        raw_clk = 1'b0;
  logic        reset = 1'b1;
  logic [1:0]  address = 2'd0;
  logic [15:0] data_in = 16'd0;
  logic        write_enable = 1'b0;
  logic        read_enable = 1'b0;
  logic [15:0] data_out;
  logic        cs_n;
  logic        spi_start;
  logic [3:0]  spi_divisor;
  logic        spi_width_16;
  logic [15:0] spi_data_tx;
  logic [15:0] spi_data_rx = 16'd0;
  logic        spi_busy;

  logic        eng_run = 1'b0;
  logic        eng_hold = 1'b0;
  int          eng_cnt = 0;
  logic [15:0] eng_word = 16'd0;

  int n_total = 0;
  int n_bad = 0;

  always #5 raw_clk = ~raw_clk;

  spi_control #(.DEPTH(4)) dut (
    .raw_clk      (raw_clk),
    .reset        (reset),
    .address      (address),
    .data_in      (data_in),
    .write_enable (write_enable),
    .read_enable  (read_enable),
    .data_out     (data_out),
    .cs_n         (cs_n),
    .spi_start    (spi_start),
    .spi_divisor  (spi_divisor),
    .spi_width_16 (spi_width_16),
    .spi_data_tx  (spi_data_tx),
    .spi_data_rx  (spi_data_rx),
    .spi_busy     (spi_busy)
  );

  // Loopback engine: busy from the cycle after start; upper byte is junk in 8-bit mode.
  assign spi_busy = eng_run | eng_hold;
  always @(posedge raw_clk) begin
    if (eng_cnt != 0) begin
      eng_cnt <= eng_cnt - 1;
      if (eng_cnt == 1) begin
        eng_run     <= 1'b0;
        spi_data_rx <= eng_word;
      end
    end else if (spi_start) begin
      eng_run  <= 1'b1;
      eng_cnt  <= 2 * (int'(spi_divisor) + 1) + (spi_width_16 ? 4 : 0);
      eng_word <= spi_width_16 ? spi_data_tx : {8'hC3, spi_data_tx[7:0]};
    end
  end

  task automatic chk(input string name, input logic [15:0] act, input logic [15:0] exp);
    n_total++;
    if (act !== exp) begin
      n_bad++;
      $display("FAIL %s: got %h expected %h", name, act, exp);
    end
  endtask

  task automatic fail(input string name);
    n_total++;
    n_bad++;
    $display("FAIL %s: got event expected none", name);
  endtask

  // Behavioural model
  logic [15:0] m_txq[$];
  logic [15:0] m_rxq[$];
  logic [6:0]  m_ctrl = 7'd0;
  logic [6:0]  m_ctrl_prev = 7'd0;
  logic [4:0]  m_shadow = 5'd0;
  logic        m_txovf = 1'b0, m_rxovf = 1'b0, m_xfer = 1'b0, m_live = 1'b0;
  logic [15:0] m_rx_next = 16'd0;
  logic        rd_pend = 1'b0;
  logic [15:0] rd_exp = 16'd0;
  logic        prev_start = 1'b0, prev_busy = 1'b0, cs_prev = 1'b1;
  int          cyc = 0, n_start = 0, n_fall = 0, n_rise = 0, last_fall = 0, n_busy_cs_hi = 0;
  int          start_cycs[$];

  always @(negedge raw_clk) begin
    logic [15:0] head;
    if (m_live) begin
      if (spi_start) begin
        start_cycs.push_back(cyc);
        n_start++;
        chk("start_one_cycle", 16'(prev_start), 16'd0);
        chk("start_engine_idle", 16'(spi_busy), 16'd0);
        if (m_txq.size() == 0) begin
          fail("start_without_data");
        end else begin
          head = m_txq.pop_front();
          m_shadow = {m_ctrl_prev[4], m_ctrl_prev[3:0]};
          m_rx_next = m_ctrl_prev[4] ? head : {8'h00, head[7:0]};
          chk("tx_word", spi_data_tx, m_rx_next);
          m_xfer = 1'b1;
        end
      end
      if (prev_busy && !spi_busy && m_xfer) begin
        m_xfer = 1'b0;
        if (m_rxq.size() == 4) m_rxovf = 1'b1;
        else m_rxq.push_back(m_rx_next);
      end
      chk("shadow", 16'({spi_width_16, spi_divisor}), 16'(m_shadow));
      if (!m_ctrl[6]) chk("cs_manual", 16'(cs_n), 16'(!m_ctrl[5]));
      if (rd_pend) chk("read_data", data_out, rd_exp);
      if (cs_prev && !cs_n) begin n_fall++; last_fall = cyc; end
      if (!cs_prev && cs_n) n_rise++;
      if (spi_busy && cs_n && m_ctrl[6] && !eng_hold) n_busy_cs_hi++;
      cs_prev = cs_n;
      prev_start = spi_start;
    end
    prev_busy = spi_busy;
    rd_pend = 1'b0;
    m_ctrl_prev = m_ctrl;
    if (reset) begin
      m_live = 1'b1;
      m_txq.delete();
      m_rxq.delete();
      m_ctrl = 7'd0;
      m_shadow = 5'd0;
      m_txovf = 1'b0;
      m_rxovf = 1'b0;
      m_xfer = 1'b0;
      rd_pend = 1'b1;
      rd_exp = 16'd0;
    end else begin
      if (read_enable) begin
        rd_pend = 1'b1;
        case (address)
          2'd0: rd_exp = {9'd0, m_ctrl};
          2'd1: rd_exp = {11'd0, m_txovf, m_rxovf, m_rxq.size() == 0, m_txq.size() == 4,
                          (m_txq.size() != 0) || m_xfer};
          2'd3: rd_exp = (m_rxq.size() == 0) ? 16'd0 : m_rxq.pop_front();
          default: rd_exp = 16'd0;
        endcase
      end
      if (write_enable) begin
        case (address)
          2'd0: m_ctrl = data_in[6:0];
          2'd1: begin
            if (data_in[3]) m_rxovf = 1'b0;
            if (data_in[4]) m_txovf = 1'b0;
          end
          2'd2: begin
            if (m_txq.size() == 4) m_txovf = 1'b1;
            else m_txq.push_back(data_in);
          end
          default: ;
        endcase
      end
    end
    cyc++;
  end

  task automatic tick();
    @(posedge raw_clk);
    #1;
  endtask

  task automatic bus_wr(input logic [1:0] a, input logic [15:0] d);
    address = a;
    data_in = d;
    write_enable = 1'b1;
    tick();
    write_enable = 1'b0;
  endtask

  task automatic bus_rd(input string name, input logic [1:0] a, input logic [15:0] exp);
    address = a;
    read_enable = 1'b1;
    tick();
    read_enable = 1'b0;
    chk(name, data_out, exp);
  endtask

  task automatic wait_quiet();
    int n;
    n = 0;
    while ((m_txq.size() != 0 || m_xfer || spi_busy) && n < 1000) begin
      tick();
      n++;
    end
    if (n >= 1000) fail("quiet_timeout");
    repeat (4) tick();
  endtask

  task automatic wait_busy(input logic level);
    int n;
    n = 0;
    while (spi_busy !== level && n < 200) begin
      tick();
      n++;
    end
    if (n >= 200) fail("busy_timeout");
  endtask

  initial begin
    #500000;
    $display("FAIL watchdog: got timeout expected finish");
    $fatal(1);
  end

  initial begin
    int wr_cyc, s0, f0, r0, h0;
    repeat (3) tick();
    reset = 1'b0;
    tick();
    // Reset state
    chk("reset_cs_n", 16'(cs_n), 16'd1);
    chk("reset_data_tx", spi_data_tx, 16'd0);
    bus_rd("reset_status", 2'd1, 16'h0004);
    bus_rd("reset_rx_empty", 2'd3, 16'h0000);

    // Single auto-CS word
    bus_wr(2'd0, 16'h0041);
    bus_rd("ctrl_readback", 2'd0, 16'h0041);
    s0 = n_start; f0 = n_fall; r0 = n_rise; h0 = n_busy_cs_hi;
    wr_cyc = cyc;
    bus_wr(2'd2, 16'h00A5);
    wait_quiet();
    chk("single_starts", 16'(n_start - s0), 16'd1);
    chk("single_cs_falls", 16'(n_fall - f0), 16'd1);
    chk("single_cs_rises", 16'(n_rise - r0), 16'd1);
    chk("single_cs_setup_cycle", 16'(last_fall - wr_cyc), 16'd2);
    chk("single_start_cycle", 16'(start_cycs[$] - wr_cyc), 16'd3);
    chk("single_cs_low_while_busy", 16'(n_busy_cs_hi - h0), 16'd0);
    bus_rd("single_status", 2'd1, 16'h0000);
    bus_rd("single_rx", 2'd3, 16'h00A5);

    // Back-to-back burst with the engine held busy while the FIFO fills
    eng_hold = 1'b1;
    bus_wr(2'd2, 16'h0011);
    bus_wr(2'd2, 16'h0022);
    bus_wr(2'd2, 16'h0033);
    bus_wr(2'd2, 16'h0044);
    bus_rd("burst_full", 2'd1, 16'h0007);
    bus_wr(2'd2, 16'h0055);
    bus_rd("burst_tx_ovf", 2'd1, 16'h0017);
    s0 = n_start; f0 = n_fall; r0 = n_rise; h0 = n_busy_cs_hi;
    eng_hold = 1'b0;
    wait_quiet();
    chk("burst_starts", 16'(n_start - s0), 16'd4);
    chk("burst_cs_falls", 16'(n_fall - f0), 16'd1);
    chk("burst_cs_rises", 16'(n_rise - r0), 16'd1);
    chk("burst_cs_low_while_busy", 16'(n_busy_cs_hi - h0), 16'd0);
    // 4 busy cycles (divisor 1, 8-bit) plus 3 overhead per word
    chk("burst_spacing", 16'(start_cycs[$] - start_cycs[$-3]), 16'd21);
    bus_rd("burst_rx0", 2'd3, 16'h0011);
    bus_rd("burst_rx1", 2'd3, 16'h0022);
    bus_rd("burst_rx2", 2'd3, 16'h0033);
    bus_rd("burst_rx3", 2'd3, 16'h0044);
    bus_rd("burst_status_end", 2'd1, 16'h0014);
    bus_wr(2'd1, 16'h0010);
    bus_rd("burst_tx_ovf_clear", 2'd1, 16'h0004);

    // RX overflow: five words, none read
    eng_hold = 1'b1;
    bus_wr(2'd2, 16'h0051);
    bus_wr(2'd2, 16'h0052);
    bus_wr(2'd2, 16'h0053);
    bus_wr(2'd2, 16'h0054);
    eng_hold = 1'b0;
    wait_quiet();
    bus_wr(2'd2, 16'h0055);
    wait_quiet();
    bus_rd("rx_ovf_set", 2'd1, 16'h0008);
    bus_wr(2'd1, 16'h0008);
    bus_rd("rx_ovf_clear", 2'd1, 16'h0000);
    bus_rd("rx_ovf_rx0", 2'd3, 16'h0051);
    bus_rd("rx_ovf_rx1", 2'd3, 16'h0052);
    bus_rd("rx_ovf_rx2", 2'd3, 16'h0053);
    bus_rd("rx_ovf_rx3", 2'd3, 16'h0054);
    bus_rd("rx_ovf_drained", 2'd3, 16'h0000);

    // CTRL change while word 1 is in flight applies to word 2 only
    eng_hold = 1'b1;
    bus_wr(2'd2, 16'hBEEF);
    bus_wr(2'd2, 16'h1234);
    eng_hold = 1'b0;
    tick();
    wait_busy(1'b1);
    repeat (2) tick();
    bus_wr(2'd0, 16'h0053);
    chk("shadow_div_held", 16'(spi_divisor), 16'd1);
    chk("shadow_width_held", 16'(spi_width_16), 16'd0);
    wait_quiet();
    chk("shadow_div_new", 16'(spi_divisor), 16'd3);
    chk("shadow_width_new", 16'(spi_width_16), 16'd1);
    bus_rd("width_rx0", 2'd3, 16'h00EF);
    bus_rd("width_rx1", 2'd3, 16'h1234);

    // Reset while the engine is mid-word
    bus_wr(2'd2, 16'hCAFE);
    wait_busy(1'b1);
    repeat (3) tick();
    reset = 1'b1;
    tick();
    reset = 1'b0;
    chk("midreset_cs_n", 16'(cs_n), 16'd1);
    chk("midreset_data_out", data_out, 16'd0);
    chk("midreset_data_tx", spi_data_tx, 16'd0);
    chk("midreset_start", 16'(spi_start), 16'd0);
    chk("midreset_engine_busy", 16'(spi_busy), 16'd1);
    s0 = n_start;
    wait_busy(1'b0);
    repeat (10) tick();
    chk("midreset_no_start", 16'(n_start - s0), 16'd0);
    bus_rd("midreset_status", 2'd1, 16'h0004);
    bus_wr(2'd0, 16'h0041);
    bus_wr(2'd2, 16'h005A);
    wait_quiet();
    chk("midreset_restart", 16'(n_start - s0), 16'd1);
    bus_rd("midreset_rx", 2'd3, 16'h005A);

    $display("test done: total=%0d bad=%0d", n_total, n_bad);
    $finish;
  end

endmodule
